// File: rtl/decode_stage.sv
// RV32I instruction decode stage: one-cycle ID/EX register with field decode,
// load-use interlock, jump flush and downstream hold.
module decode_stage #(
    parameter int unsigned width     = 32,
    parameter bit          HAZARD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      inst,
    input  logic [width-1:0] pc,
    input  logic             in_valid,
    input  logic             flush,
    input  logic             hold,
    output logic             stall_fetch,
    output logic             out_valid,
    output logic [width-1:0] out_pc,
    output logic [3:0]       op_class,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [2:0]       funct3,
    output logic             alt,
    output logic [31:0]      imm,
    output logic             illegal
);

    typedef enum logic [3:0] {
        OPC_NONE   = 4'd0,
        OPC_LUI    = 4'd1,
        OPC_AUIPC  = 4'd2,
        OPC_JAL    = 4'd3,
        OPC_JALR   = 4'd4,
        OPC_BRANCH = 4'd5,
        OPC_LOAD   = 4'd6,
        OPC_STORE  = 4'd7,
        OPC_OPIMM  = 4'd8,
        OPC_OP     = 4'd9,
        OPC_FENCE  = 4'd10,
        OPC_SYSTEM = 4'd11
    } op_class_e;

    typedef struct packed {
        op_class_e   cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic        alt;
        logic [31:0] imm;
        logic        illegal;
    } dec_t;

    logic             valid_q, valid_d;
    logic [width-1:0] pc_q, pc_d;
    dec_t             dec_q, dec_d;
    dec_t             dec_in;
    logic             reads_rs1, reads_rs2;
    logic             hazard;

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // Decode the incoming instruction; fields absent from the format stay zero
    always_comb begin
        dec_in    = '0;
        reads_rs1 = 1'b0;
        reads_rs2 = 1'b0;
        if (inst[1:0] != 2'b11) begin
            dec_in.illegal = 1'b1;
        end else begin
            case (inst[6:2])
                5'b01101: begin
                    dec_in.cls = OPC_LUI;
                    dec_in.rd  = inst[11:7];
                    dec_in.imm = imm_u;
                end
                5'b00101: begin
                    dec_in.cls = OPC_AUIPC;
                    dec_in.rd  = inst[11:7];
                    dec_in.imm = imm_u;
                end
                5'b11011: begin
                    dec_in.cls = OPC_JAL;
                    dec_in.rd  = inst[11:7];
                    dec_in.imm = imm_j;
                end
                5'b11001: begin
                    dec_in.cls = OPC_JALR;
                    dec_in.rd  = inst[11:7];
                    dec_in.rs1 = inst[19:15];
                    dec_in.f3  = inst[14:12];
                    dec_in.imm = imm_i;
                    reads_rs1  = 1'b1;
                end
                5'b11000: begin
                    dec_in.cls = OPC_BRANCH;
                    dec_in.rs1 = inst[19:15];
                    dec_in.rs2 = inst[24:20];
                    dec_in.f3  = inst[14:12];
                    dec_in.imm = imm_b;
                    reads_rs1  = 1'b1;
                    reads_rs2  = 1'b1;
                end
                5'b00000: begin
                    dec_in.cls = OPC_LOAD;
                    dec_in.rd  = inst[11:7];
                    dec_in.rs1 = inst[19:15];
                    dec_in.f3  = inst[14:12];
                    dec_in.imm = imm_i;
                    reads_rs1  = 1'b1;
                end
                5'b01000: begin
                    dec_in.cls = OPC_STORE;
                    dec_in.rs1 = inst[19:15];
                    dec_in.rs2 = inst[24:20];
                    dec_in.f3  = inst[14:12];
                    dec_in.imm = imm_s;
                    reads_rs1  = 1'b1;
                    reads_rs2  = 1'b1;
                end
                5'b00100: begin
                    dec_in.cls = OPC_OPIMM;
                    dec_in.rd  = inst[11:7];
                    dec_in.rs1 = inst[19:15];
                    dec_in.f3  = inst[14:12];
                    dec_in.alt = (inst[14:12] == 3'b101) ? inst[30] : 1'b0;
                    dec_in.imm = imm_i;
                    reads_rs1  = 1'b1;
                end
                5'b01100: begin
                    dec_in.cls = OPC_OP;
                    dec_in.rd  = inst[11:7];
                    dec_in.rs1 = inst[19:15];
                    dec_in.rs2 = inst[24:20];
                    dec_in.f3  = inst[14:12];
                    dec_in.alt = inst[30];
                    reads_rs1  = 1'b1;
                    reads_rs2  = 1'b1;
                end
                5'b00011: begin
                    dec_in.cls = OPC_FENCE;
                    dec_in.rd  = inst[11:7];
                    dec_in.rs1 = inst[19:15];
                    dec_in.f3  = inst[14:12];
                    dec_in.imm = imm_i;
                end
                5'b11100: begin
                    dec_in.cls = OPC_SYSTEM;
                    dec_in.rd  = inst[11:7];
                    dec_in.rs1 = inst[19:15];
                    dec_in.f3  = inst[14:12];
                    dec_in.imm = imm_i;
                end
                default: dec_in.illegal = 1'b1;
            endcase
        end
    end

    // Load-use interlock against the load currently held in ID/EX
    always_comb begin
        hazard = HAZARD_EN && valid_q && (dec_q.cls == OPC_LOAD) && (dec_q.rd != 5'd0)
                 && in_valid
                 && ((reads_rs1 && (dec_in.rs1 == dec_q.rd)) ||
                     (reads_rs2 && (dec_in.rs2 == dec_q.rd)));
        stall_fetch = rst & ~flush & (hold | hazard);
    end

    // Next ID/EX contents: flush > hold > hazard bubble > accept > idle bubble
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        dec_d   = dec_q;
        if (flush) begin
            valid_d = 1'b0;
            pc_d    = '0;
            dec_d   = '0;
        end else if (hold) begin
            valid_d = valid_q;
        end else if (hazard || !in_valid) begin
            valid_d = 1'b0;
            pc_d    = '0;
            dec_d   = '0;
        end else begin
            valid_d = 1'b1;
            pc_d    = pc;
            dec_d   = dec_in;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            dec_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            dec_q   <= dec_d;
        end
    end

    assign out_valid = valid_q;
    assign out_pc    = pc_q;
    assign op_class  = dec_q.cls;
    assign rd        = dec_q.rd;
    assign rs1       = dec_q.rs1;
    assign rs2       = dec_q.rs2;
    assign funct3    = dec_q.f3;
    assign alt       = dec_q.alt;
    assign imm       = dec_q.imm;
    assign illegal   = dec_q.illegal;

endmodule
